hex_scan_driver: RTL and testbench
==================================

// Module: hex_scan_driver
// PURPOSE
//   Time-multiplexes a 16-bit hex value onto NUM_DIGITS common-anode digits through
//   one shared seven-segment decoder. Sits directly upstream of the decoder: drives
//   its 4-bit nibble input and blank-enable, plus the board's active-low anode lines.
//   Includes a refresh prescaler, a digit scan counter, tear-free value commit at frame
//   boundaries, and optional leading-zero blanking.
// PARAMETERS
//   CLK_DIV     50000  clk cycles per digit slot (>=2); 1 kHz slot rate at 50 MHz
//   NUM_DIGITS  4      digits scanned; value width = 4*NUM_DIGITS
// PORTS
//   clk         in   1             system clock, all logic on rising edge
//   rst_n       in   1             asynchronous, active-low reset
//   value       in   4*NUM_DIGITS  hex value to display; nibble i -> digit i (0 = rightmost)
//   load        in   1             1-cycle strobe; captures value into pending register
//   blank_lz    in   1             1 = blank leading zero digits (level, sampled per slot)
//   digit       out  4             nibble for current slot, to decoder data input
//   digit_en    out  1             1 = decoder shows digit, 0 = decoder blanks
//   an          out  NUM_DIGITS    anode select, active-low, exactly one low while scanning
//   frame_done  out  1             1-cycle pulse when a pending value is committed
// BEHAVIOUR
//   Reset (async assert, sync release): prescaler=0, idx=0, pend_reg=0, disp_reg=0,
//     pend_valid=0; outputs an=all 1s, digit=0, digit_en=0, frame_done=0.
//   Prescaler: cnt counts 0..CLK_DIV-1, width $clog2(CLK_DIV); tick=(cnt==CLK_DIV-1),
//     cnt wraps to 0 on the same edge. First tick occurs CLK_DIV edges after release.
//   On each tick edge (all outputs registered):
//     an <= ~(1<<idx); digit <= disp_reg[4*idx+:4]; digit_en <= ~blank(idx);
//     idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1.
//   Between ticks all outputs hold; an never shows zero or two low bits after first tick.
//   blank(i) = blank_lz && i!=0 && disp_reg[4*NUM_DIGITS-1:4*i]==0. Digit 0 never blanked,
//     so value 0 shows a single "0".
//   Load: load=1 -> pend_reg<=value, pend_valid<=1. Later loads before commit overwrite.
//   Commit: on a tick edge with idx==NUM_DIGITS-1 and (pend_valid || load):
//     disp_reg <= load ? value : pend_reg; pend_valid<=0; frame_done<=1 next cycle only.
//     Digit emitted on that same edge uses OLD disp_reg; new value starts at digit 0.
//   Load coinciding with commit edge: bypass, that value is committed, pend_valid ends 0.
//   No commit, no frame_done when nothing pending; disp_reg persists indefinitely.
//   rst_n asserted mid-frame: outputs go to reset values immediately; pending value lost.
// STRUCTURE
//   Shared package: DIGIT_W=4, anode OFF pattern (all 1s), default CLK_DIV, NUM_DIGITS.
//   One sub-module: scan_tick_gen (prescaler, param CLK_DIV, outputs tick). Scan counter,
//   value registers, blanking and output registers stay in this module.
// TESTING  (CLK_DIV=4, NUM_DIGITS=4)
//   Reset: rst_n low 3 cycles -> an=1111, digit_en=0, digit=0, frame_done=0; first
//     change on 4th edge after release: an=1110.
//   load value=16'h1A3F, run 2 frames -> first frame after commit shows F,3,A,1 on
//     an=1110,1101,1011,0111, 4 cycles each, digit_en=1; frame_done one pulse.
//   blank_lz=1, value=16'h0050 -> digit_en pattern 1,1,0,0 for digits 0..3;
//     value=16'h0000 -> 1,0,0,0 with digit=0 on digit 0; blank_lz=0 -> all 1.
//   Loads 16'h1111 then 16'h2222 within one frame -> only 2222 ever displayed, one
//     frame_done; load 16'h3333 exactly on commit edge -> 3333 shown next frame.
//   Assert rst_n low while idx=2 -> outputs immediately reset values; restart at digit 0,
//     disp_reg=0.
//   No load for 3 frames -> frame_done stays 0, display content unchanged.

Source files
------------

// File: rtl/hex_scan_driver_pkg.sv
// Shared constants for the hex scan driver and its prescaler.
//   DIGIT_W        : width of one hex digit (decoder data input width)
//   DEF_CLK_DIV    : default clk cycles per digit slot (1 kHz slots at 50 MHz)
//   DEF_NUM_DIGITS : default number of scanned digits
//   MAX_DIGITS     : widest anode bus the OFF pattern below covers
//   AN_OFF_MAX     : all anodes off (common-anode, active-low lines all high)
package hex_scan_driver_pkg;

  localparam int DIGIT_W        = 4;
  localparam int DEF_CLK_DIV    = 50000;
  localparam int DEF_NUM_DIGITS = 4;
  localparam int MAX_DIGITS     = 16;

  localparam logic [MAX_DIGITS-1:0] AN_OFF_MAX = {MAX_DIGITS{1'b1}};

endpackage

// File: rtl/hex_scan_driver_scan_tick_gen.sv
// Refresh prescaler: counts 0..CLK_DIV-1 and flags the last count, which is the
// cycle whose rising edge advances the digit scan. The counter wraps on that edge,
// so the first tick edge is the CLK_DIV-th rising edge after reset release.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   o_tick : high during the last cycle of each digit slot
module scan_tick_gen
  import hex_scan_driver_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int               CNT_W   = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  assign w_tick = (r_cnt == CNT_MAX);
  assign o_tick = w_tick;

  // Slot prescaler, wraps to zero on the tick edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_tick) begin
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexes a hex value onto NUM_DIGITS common-anode digits through one
// shared seven-segment decoder. A value is captured on load into a pending
// register and only moves to the displayed register at a frame boundary (tick
// on the last digit), so a frame never mixes two values.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   value      : hex value, nibble i drives digit i (0 = rightmost)
//   load       : 1-cycle strobe capturing value as pending
//   blank_lz   : 1 = blank leading zero digits (digit 0 always shown)
//   digit      : nibble for the current slot (decoder data input)
//   digit_en   : 1 = decoder shows digit, 0 = decoder blanks
//   an         : active-low anode selects, one low per slot once scanning
//   frame_done : 1-cycle pulse after a pending value is committed
module hex_scan_driver
  import hex_scan_driver_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int NUM_DIGITS = DEF_NUM_DIGITS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] value,
  input  logic                          load,
  input  logic                          blank_lz,
  output logic [DIGIT_W-1:0]            digit,
  output logic                          digit_en,
  output logic [NUM_DIGITS-1:0]         an,
  output logic                          frame_done
);

  localparam int                    VAL_W    = DIGIT_W * NUM_DIGITS;
  localparam int                    IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = AN_OFF_MAX[NUM_DIGITS-1:0];

  logic                  w_tick;
  logic [IDX_W-1:0]      r_idx;
  logic [VAL_W-1:0]      r_pend;
  logic                  r_pend_valid;
  logic [VAL_W-1:0]      r_disp;
  logic [NUM_DIGITS-1:0] r_an;
  logic [DIGIT_W-1:0]    r_digit;
  logic                  r_digit_en;
  logic                  r_frame_done;

  logic [DIGIT_W-1:0]    w_nibs [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_hi_zero;
  logic [NUM_DIGITS-1:0] w_an_sel;
  logic [DIGIT_W-1:0]    w_nib;
  logic                  w_blank;
  logic                  w_commit;

  scan_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_tick)
  );

  // Per-digit nibble, anode pattern and "this digit and everything above it is
  // zero" flag; digit 0 never counts as a leading zero.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign w_nibs[gi]   = r_disp[DIGIT_W*gi +: DIGIT_W];
    assign w_an_sel[gi] = (r_idx != IDX_W'(gi));
    if (gi == 0) begin : g_lsd
      assign w_hi_zero[gi] = 1'b0;
    end else begin : g_upper
      assign w_hi_zero[gi] = (r_disp[VAL_W-1:DIGIT_W*gi] == {(VAL_W-DIGIT_W*gi){1'b0}});
    end
  end

  assign w_nib    = w_nibs[r_idx];
  assign w_blank  = blank_lz & w_hi_zero[r_idx];
  // A load landing on the commit edge is bypassed straight into the display.
  assign w_commit = w_tick && (r_idx == IDX_LAST) && (r_pend_valid || load);

  // Digit scan counter and registered decoder/anode outputs, updated per slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= {IDX_W{1'b0}};
      r_an       <= AN_OFF;
      r_digit    <= {DIGIT_W{1'b0}};
      r_digit_en <= 1'b0;
    end else if (w_tick) begin
      r_an       <= w_an_sel;
      r_digit    <= w_nib;
      r_digit_en <= ~w_blank;
      r_idx      <= (r_idx == IDX_LAST) ? {IDX_W{1'b0}} : r_idx + IDX_W'(1);
    end
  end

  // Pending capture, frame-boundary commit and the commit strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend       <= {VAL_W{1'b0}};
      r_pend_valid <= 1'b0;
      r_disp       <= {VAL_W{1'b0}};
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (load) begin
        r_pend <= value;
      end
      if (w_commit) begin
        r_disp       <= load ? value : r_pend;
        r_pend_valid <= 1'b0;
        r_frame_done <= 1'b1;
      end else if (load) begin
        r_pend_valid <= 1'b1;
      end
    end
  end

  assign an         = r_an;
  assign digit      = r_digit;
  assign digit_en   = r_digit_en;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed bench for hex_scan_driver with CLK_DIV=4, NUM_DIGITS=4.
// Inputs change and outputs are sampled on the falling clock edge. Each table
// record covers one digit slot: it drives its inputs at the start of the slot,
// checks that all outputs hold through the slot, and checks the outputs
// produced by the tick edge that ends the slot.
module tb_hex_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  logic [3:0]  digit;
  logic        digit_en;
  logic [3:0]  an;
  logic        frame_done;

  hex_scan_driver #(
    .CLK_DIV    (4),
    .NUM_DIGITS (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .blank_lz   (blank_lz),
    .digit      (digit),
    .digit_en   (digit_en),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [15:0] val;
    logic        bl;
    logic [3:0]  ea;
    logic [3:0]  ed;
    logic        ee;
    logic        ef;
  } vec_t;

  vec_t tbl[$];

  int n_vec  = 0;
  int n_miss = 0;

  logic [3:0] prev_an;
  logic [3:0] prev_digit;
  logic       prev_en;

  task automatic add(input logic ld, input logic [15:0] val, input logic bl,
                     input logic [3:0] ea, input logic [3:0] ed, input logic ee,
                     input logic ef);
    tbl.push_back('{ld, val, bl, ea, ed, ee, ef});
  endtask

  task automatic check_out(input string nm, input logic [3:0] ea, input logic [3:0] ed,
                           input logic ee, input logic ef);
    n_vec++;
    if (an !== ea || digit !== ed || digit_en !== ee || frame_done !== ef) begin
      n_miss++;
      $display("FAIL %s: got an=%b digit=%h en=%b fd=%b, expected an=%b digit=%h en=%b fd=%b",
               nm, an, digit, digit_en, frame_done, ea, ed, ee, ef);
    end
  endtask

  // One digit slot: drive inputs, verify hold for 3 cycles, verify tick result.
  task automatic step(input string nm, input logic ld, input logic [15:0] val,
                      input logic bl, input logic [3:0] ea, input logic [3:0] ed,
                      input logic ee, input logic ef);
    load     = ld;
    blank_lz = bl;
    if (ld) value = val;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      load = 1'b0;
      check_out({nm, "_hold"}, prev_an, prev_digit, prev_en, 1'b0);
    end
    @(negedge clk);
    check_out(nm, ea, ed, ee, ef);
    prev_an    = ea;
    prev_digit = ed;
    prev_en    = ee;
  endtask

  initial begin
    logic [3:0] one;
    logic [3:0] ea;
    one      = 4'b0001;
    rst_n    = 1'b0;
    load     = 1'b0;
    value    = 16'h0000;
    blank_lz = 1'b0;

    // Load 1A3F, commit at end of first frame, show it in the second.
    add(1'b1, 16'h1A3F, 1'b0, 4'hE, 4'h0, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 4'hD, 4'h0, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 4'hB, 4'h0, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 4'h7, 4'h0, 1'b1, 1'b1);
    add(1'b0, 16'h0000, 1'b0, 4'hE, 4'hF, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 4'hD, 4'h3, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 4'hB, 4'hA, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 4'h7, 4'h1, 1'b1, 1'b0);
    // Blanking on: 1A3F has no leading zeros; load 0050.
    add(1'b1, 16'h0050, 1'b1, 4'hE, 4'hF, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 4'hD, 4'h3, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 4'hB, 4'hA, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 4'h7, 4'h1, 1'b1, 1'b1);
    // 0050 with blanking: enables 1,1,0,0.
    add(1'b0, 16'h0000, 1'b1, 4'hE, 4'h0, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 4'hD, 4'h5, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 4'hB, 4'h0, 1'b0, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 4'h7, 4'h0, 1'b0, 1'b0);
    // Load 0000, still showing 0050 this frame.
    add(1'b1, 16'h0000, 1'b1, 4'hE, 4'h0, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 4'hD, 4'h5, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 4'hB, 4'h0, 1'b0, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 4'h7, 4'h0, 1'b0, 1'b1);
    // 0000 with blanking: single "0" on digit 0.
    add(1'b0, 16'h0000, 1'b1, 4'hE, 4'h0, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 4'hD, 4'h0, 1'b0, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 4'hB, 4'h0, 1'b0, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 4'h7, 4'h0, 1'b0, 1'b0);
    // Blanking off: all digits shown.
    add(1'b0, 16'h0000, 1'b0, 4'hE, 4'h0, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 4'hD, 4'h0, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 4'hB, 4'h0, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 4'h7, 4'h0, 1'b1, 1'b0);
    // 1111 overwritten by 2222 before commit: one commit, only 2222 shown.
    add(1'b1, 16'h1111, 1'b0, 4'hE, 4'h0, 1'b1, 1'b0);
    add(1'b1, 16'h2222, 1'b0, 4'hD, 4'h0, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 4'hB, 4'h0, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 4'h7, 4'h0, 1'b1, 1'b1);
    add(1'b0, 16'h0000, 1'b0, 4'hE, 4'h2, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 4'hD, 4'h2, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 4'hB, 4'h2, 1'b1, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 4'h7, 4'h2, 1'b1, 1'b0);

    // Reset held 3 cycles.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_out("reset_state", 4'hF, 4'h0, 1'b0, 1'b0);
    end
    rst_n      = 1'b1;
    prev_an    = 4'hF;
    prev_digit = 4'h0;
    prev_en    = 1'b0;

    foreach (tbl[i]) begin
      step($sformatf("vec%0d", i), tbl[i].ld, tbl[i].val, tbl[i].bl,
           tbl[i].ea, tbl[i].ed, tbl[i].ee, tbl[i].ef);
    end

    // Three slots, then a load landing exactly on the commit edge.
    step("pre_bypass0", 1'b0, 16'h0000, 1'b0, 4'hE, 4'h2, 1'b1, 1'b0);
    step("pre_bypass1", 1'b0, 16'h0000, 1'b0, 4'hD, 4'h2, 1'b1, 1'b0);
    step("pre_bypass2", 1'b0, 16'h0000, 1'b0, 4'hB, 4'h2, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    load  = 1'b1;
    value = 16'h3333;
    @(negedge clk);
    load = 1'b0;
    check_out("bypass_commit", 4'h7, 4'h2, 1'b1, 1'b1);
    prev_an    = 4'h7;
    prev_digit = 4'h2;
    prev_en    = 1'b1;

    // Three frames with no load: 3333 shown, no further commits.
    for (int k = 0; k < 12; k++) begin
      ea = ~(one << (k % 4));
      step($sformatf("idle%0d", k), 1'b0, 16'h0000, 1'b0, ea, 4'h3, 1'b1, 1'b0);
    end

    // Reset asserted with idx=2 and a value pending.
    step("pre_rst0", 1'b0, 16'h0000, 1'b0, 4'hE, 4'h3, 1'b1, 1'b0);
    step("pre_rst1", 1'b0, 16'h0000, 1'b0, 4'hD, 4'h3, 1'b1, 1'b0);
    load  = 1'b1;
    value = 16'hAAAA;
    @(negedge clk);
    load = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_out("async_reset", 4'hF, 4'h0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_out("reset_hold", 4'hF, 4'h0, 1'b0, 1'b0);
    end
    rst_n      = 1'b1;
    prev_an    = 4'hF;
    prev_digit = 4'h0;
    prev_en    = 1'b0;
    step("restart0", 1'b0, 16'h0000, 1'b0, 4'hE, 4'h0, 1'b1, 1'b0);
    step("restart1", 1'b0, 16'h0000, 1'b0, 4'hD, 4'h0, 1'b1, 1'b0);
    step("restart2", 1'b0, 16'h0000, 1'b0, 4'hB, 4'h0, 1'b1, 1'b0);
    step("restart3", 1'b0, 16'h0000, 1'b0, 4'h7, 4'h0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
